// File: rtl/data_skew_feeder.sv
// Double-buffered activation feeder: ping/pong lane RAMs streamed into the systolic array with per-lane diagonal skew.
// Optional FEEDER_STALL_EN adds sa_stall_i, which freezes the read pipeline while high.
module data_skew_feeder #(
    parameter int NUM_LANES  = 25,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 1024,
    parameter int BURST_W    = 11,
    localparam int LANE_W    = $clog2(NUM_LANES),
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr_en,
    input  logic [LANE_W-1:0]               wr_lane,
    input  logic [ADDR_W-1:0]               wr_addr,
    input  logic [DATA_WIDTH-1:0]           wr_data,
    input  logic                            wr_commit,
    output logic                            wr_ready_o,
    input  logic [BURST_W-1:0]              burst_size_i,
    input  logic                            weight_ready_i,
`ifdef FEEDER_STALL_EN
    input  logic                            sa_stall_i,
`endif
    output logic [NUM_LANES-1:0]            data_valid_o,
    output logic [NUM_LANES*DATA_WIDTH-1:0] sa_data_o,
    output logic                            burst_last_o,
    output logic                            busy_o
);

    localparam int LEN_W = ADDR_W + 1;
    localparam int CNT_W = $clog2(NUM_LANES) + 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_DRAIN  = 2'd3;

    logic [1:0]       state;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] rd_cnt;
    logic [CNT_W-1:0] drain_cnt;
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       full;
    logic             stall;

`ifdef FEEDER_STALL_EN
    assign stall = sa_stall_i;
`else
    assign stall = 1'b0;
`endif

    logic             do_wr;
    logic             do_commit;
    logic             addr_ok;
    logic             release_bank;
    logic             rd_en;
    logic             rd_last;
    logic [31:0]      burst_ext;
    logic [LEN_W-1:0] len_next;

    assign wr_ready_o   = ~full[wr_ptr];
    assign addr_ok      = 32'(wr_addr) < 32'(DEPTH);
    assign do_wr        = rst & wr_en & wr_ready_o & addr_ok;
    assign do_commit    = wr_commit & wr_ready_o;
    assign release_bank = (state == S_DRAIN) && !stall && (drain_cnt == CNT_W'(NUM_LANES - 1));
    assign rd_en        = (state == S_STREAM) && !stall;
    assign rd_last      = (rd_cnt == len - LEN_W'(1));
    assign busy_o       = (state != S_IDLE);

    // Unsigned clamp of the requested burst length to one bank's depth.
    assign burst_ext = 32'(burst_size_i);
    assign len_next  = (burst_ext > 32'(DEPTH)) ? LEN_W'(DEPTH) : LEN_W'(burst_size_i);

    // Commit and release always address different banks, so both may land in one cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            full   <= 2'b00;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (do_commit) begin
                full[wr_ptr] <= 1'b1;
                wr_ptr       <= ~wr_ptr;
            end
            if (release_bank) begin
                full[rd_ptr] <= 1'b0;
                rd_ptr       <= ~rd_ptr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            len       <= '0;
            rd_cnt    <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (full[rd_ptr] && (burst_size_i != '0)) begin
                        len   <= len_next;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (weight_ready_i) begin
                        rd_cnt <= '0;
                        state  <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (!stall) begin
                        rd_cnt <= rd_cnt + LEN_W'(1);
                        if (rd_last) begin
                            drain_cnt <= '0;
                            state     <= S_DRAIN;
                        end
                    end
                end
                default: begin
                    if (!stall) begin
                        if (drain_cnt == CNT_W'(NUM_LANES - 1)) begin
                            state <= S_IDLE;
                        end else begin
                            drain_cnt <= drain_cnt + CNT_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    // Stage 0 of these chains is the RAM output register; lane k taps stage k.
    logic [NUM_LANES-1:0] vld_chain;
    logic [NUM_LANES-1:0] last_chain;

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_chain  <= '0;
            last_chain <= '0;
        end else if (!stall) begin
            vld_chain[0]  <= (state == S_STREAM);
            last_chain[0] <= (state == S_STREAM) && rd_last;
            for (int j = 1; j < NUM_LANES; j++) begin
                vld_chain[j]  <= vld_chain[j-1];
                last_chain[j] <= last_chain[j-1];
            end
        end
    end

    assign data_valid_o = vld_chain;

`ifdef FEEDER_STALL_EN
    // A held pipeline repeats its outputs; suppress the repeat of the last-element pulse.
    logic stall_q;
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_q <= 1'b0;
        end else begin
            stall_q <= stall;
        end
    end
    assign burst_last_o = last_chain[NUM_LANES-1] & ~stall_q;
`else
    assign burst_last_o = last_chain[NUM_LANES-1];
`endif

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        logic [DATA_WIDTH-1:0] mem [2][DEPTH];
        logic [DATA_WIDTH-1:0] rd_q;
        logic [DATA_WIDTH-1:0] lane_data;

        always_ff @(posedge clk) begin
            if (do_wr && (wr_lane == LANE_W'(k))) begin
                mem[wr_ptr][wr_addr] <= wr_data;
            end
            if (rd_en) begin
                rd_q <= mem[rd_ptr][rd_cnt[ADDR_W-1:0]];
            end
        end

        if (k == 0) begin : g_noskew
            assign lane_data = rd_q;
        end else begin : g_skew
            logic [DATA_WIDTH-1:0] skew [1:k];
            always_ff @(posedge clk) begin
                if (!stall) begin
                    skew[1] <= rd_q;
                    for (int j = 2; j <= k; j++) begin
                        skew[j] <= skew[j-1];
                    end
                end
            end
            assign lane_data = skew[k];
        end

        assign sa_data_o[k*DATA_WIDTH +: DATA_WIDTH] = vld_chain[k] ? lane_data : '0;
    end

endmodule

// File: tb/tb_data_skew_feeder.sv
// Scoreboard bench for data_skew_feeder: expected (cycle, data) pairs per lane are queued when a burst starts.
// Five lanes are used so that an out-of-range wr_lane value is representable on the port.
module tb_data_skew_feeder;

  localparam int NL    = 5;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int BW    = 11;

  logic            clk = 1'b0;
  logic            rst;
  logic            wr_en;
  logic [2:0]      wr_lane;
  logic [3:0]      wr_addr;
  logic [DW-1:0]   wr_data;
  logic            wr_commit;
  logic            wr_ready_o;
  logic [BW-1:0]   burst_size_i;
  logic            weight_ready_i;
  logic            sa_stall_i;
  logic [NL-1:0]   data_valid_o;
  logic [NL*DW-1:0] sa_data_o;
  logic            burst_last_o;
  logic            busy_o;

  data_skew_feeder #(
    .NUM_LANES(NL), .DATA_WIDTH(DW), .DEPTH(DEPTH), .BURST_W(BW)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_lane(wr_lane), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_commit(wr_commit), .wr_ready_o(wr_ready_o),
    .burst_size_i(burst_size_i), .weight_ready_i(weight_ready_i),
`ifdef FEEDER_STALL_EN
    .sa_stall_i(sa_stall_i),
`endif
    .data_valid_o(data_valid_o), .sa_data_o(sa_data_o),
    .burst_last_o(burst_last_o), .busy_o(busy_o)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int n_tests = 0;
  int n_fail  = 0;
  logic        mon_en = 1'b0;
  logic [39:0] exp_q [NL][$];
  logic [31:0] last_q [$];
  logic [39:0] m_item;
  logic [31:0] m_last;
  logic [DW-1:0] m_val;

  logic [DW-1:0] mdl_mem [2][NL][DEPTH];
  logic [1:0]    mdl_full;
  int            mdl_wp;
  int            mdl_rp;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < NL; k++) begin
        m_val = sa_data_o[k*DW +: DW];
        if (exp_q[k].size() > 0 && exp_q[k][0][39:8] < 32'(cyc)) begin
          m_item = exp_q[k].pop_front();
          check($sformatf("lane%0d_missing", k), 64'(cyc), 64'(m_item[39:8]));
        end
        if (data_valid_o[k] === 1'b1) begin
          if (exp_q[k].size() == 0) begin
            check($sformatf("lane%0d_extra_valid", k), 1, 0);
          end else begin
            m_item = exp_q[k].pop_front();
            check($sformatf("lane%0d_cycle", k), 64'(cyc), 64'(m_item[39:8]));
            check($sformatf("lane%0d_data", k), 64'(m_val), 64'(m_item[7:0]));
          end
        end else begin
          check($sformatf("lane%0d_zero", k), 64'(m_val), 0);
        end
      end
      if (last_q.size() > 0 && last_q[0] < 32'(cyc)) begin
        m_last = last_q.pop_front();
        check("last_missing", 64'(cyc), 64'(m_last));
      end
      if (burst_last_o === 1'b1) begin
        if (last_q.size() == 0) begin
          check("last_extra", 1, 0);
        end else begin
          m_last = last_q.pop_front();
          check("last_cycle", 64'(cyc), 64'(m_last));
        end
      end
    end
  end

  function automatic int pending();
    int s = last_q.size();
    for (int k = 0; k < NL; k++) s += exp_q[k].size();
    return s;
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_write(input int lane, input int addr, input int data);
    wr_en   = 1'b1;
    wr_lane = 3'(lane);
    wr_addr = 4'(addr);
    wr_data = DW'(data);
    if (!mdl_full[mdl_wp] && lane < NL) mdl_mem[mdl_wp][lane][addr] = DW'(data);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic drive_commit();
    wr_commit = 1'b1;
    if (!mdl_full[mdl_wp]) begin
      mdl_full[mdl_wp] = 1'b1;
      mdl_wp ^= 1;
    end
    tick();
    wr_commit = 1'b0;
  endtask

  task automatic fill(input bit ramp);
    for (int k = 0; k < NL; k++)
      for (int a = 0; a < DEPTH; a++)
        drive_write(k, a, ramp ? (16 * k + a) : int'($urandom_range(0, 255)));
  endtask

  task automatic release_model();
    mdl_full[mdl_rp] = 1'b0;
    mdl_rp ^= 1;
  endtask

  // Queue one burst started at cycle t; a stall of stall_len cycles from stall_at shifts later items.
  task automatic push_burst(input int t, input int bank, input int len, input int stall_at, input int stall_len);
    int c;
    for (int k = 0; k < NL; k++) begin
      for (int i = 0; i < len; i++) begin
        c = t + 2 + i + k;
        if (stall_len == 0 || c < stall_at) begin
          exp_q[k].push_back({32'(c), mdl_mem[bank][k][i]});
        end else if (c == stall_at) begin
          for (int r = 0; r <= stall_len; r++) exp_q[k].push_back({32'(c + r), mdl_mem[bank][k][i]});
        end else begin
          exp_q[k].push_back({32'(c + stall_len), mdl_mem[bank][k][i]});
        end
      end
    end
    c = t + len + NL;
    if (stall_len != 0 && c > stall_at) c += stall_len;
    last_q.push_back(32'(c));
  endtask

  task automatic wait_busy();
    int n = 0;
    while (busy_o !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("busy_rise", 64'(busy_o), 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while ((pending() != 0 || busy_o !== 1'b0) && n < 400) begin
      tick();
      n++;
    end
    check("burst_done", 64'(n < 400), 1);
  endtask

  task automatic flush_after(input int cut);
    for (int k = 0; k < NL; k++)
      while (exp_q[k].size() > 0 && exp_q[k][$][39:8] > 32'(cut)) void'(exp_q[k].pop_back());
    while (last_q.size() > 0 && last_q[$] > 32'(cut)) void'(last_q.pop_back());
  endtask

  int t0;
  int t1;
  int bank_a;
  int bank_b;

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_lane = '0; wr_addr = '0; wr_data = '0;
    wr_commit = 1'b0; burst_size_i = '0; weight_ready_i = 1'b0; sa_stall_i = 1'b0;
    mdl_full = 2'b00; mdl_wp = 0; mdl_rp = 0;

    // reset state
    repeat (3) tick();
    check("rst_valid", 64'(data_valid_o), 0);
    check("rst_data", 64'(sa_data_o), 0);
    check("rst_last", 64'(burst_last_o), 0);
    check("rst_busy", 64'(busy_o), 0);
    check("rst_wr_ready", 64'(wr_ready_o), 1);
    rst = 1'b1;
    mon_en = 1'b1;
    tick();

    // basic burst of 5 from a ramp-filled bank, plus ignored out-of-range lane writes
    fill(1'b1);
    drive_write(5, 3, 8'hAA);
    drive_write(7, 0, 8'h55);
    burst_size_i = 11'd5;
    drive_commit();
    check("basic_wr_ready", 64'(wr_ready_o), 1);
    wait_busy();
    weight_ready_i = 1'b1;
    t0 = cyc;
    push_burst(t0, mdl_rp, 5, 0, 0);
    tick();
    weight_ready_i = 1'b0;
    wait_done();
    release_model();

    // zero-length request, weight gating, ping-pong with clamped bursts
    bank_a = mdl_wp;
    fill(1'b0);
    burst_size_i = 11'd0;
    drive_commit();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("zero_len_idle", 64'(busy_o), 0);
    end
    burst_size_i = 11'd2000;
    wait_busy();
    for (int i = 0; i < 20; i++) begin
      sa_stall_i = (i >= 5 && i < 9);
      tick();
      check("gate_busy", 64'(busy_o), 1);
      check("gate_valid", 64'(data_valid_o), 0);
    end
    sa_stall_i = 1'b0;
    bank_b = mdl_wp;
    fill(1'b0);
    drive_commit();
    check("pp_wr_ready_full", 64'(wr_ready_o), 0);
    check("pp_still_waiting", 64'(busy_o), 1);
    weight_ready_i = 1'b1;
    t0 = cyc;
    t1 = t0 + DEPTH + NL + 2;
    push_burst(t0, bank_a, DEPTH, 0, 0);
    push_burst(t1, bank_b, DEPTH, 0, 0);
    tick();
    tick();
    drive_write(0, DEPTH - 1, ~int'(mdl_mem[bank_a][0][DEPTH-1]));
    while (cyc < t0 + DEPTH + NL) tick();
    check("pp_wr_ready_at_last", 64'(wr_ready_o), 0);
    tick();
    check("pp_wr_ready_released", 64'(wr_ready_o), 1);
    while (cyc < t1 + 1) tick();
    weight_ready_i = 1'b0;
    burst_size_i = 11'd0;
    wait_done();
    release_model();
    release_model();

    // reset in the middle of an 8-element burst, then restream
    fill(1'b0);
    burst_size_i = 11'd8;
    drive_commit();
    wait_busy();
    weight_ready_i = 1'b1;
    t0 = cyc;
    push_burst(t0, mdl_rp, 8, 0, 0);
    tick();
    weight_ready_i = 1'b0;
    while (cyc < t0 + 4) tick();
    rst = 1'b0;
    flush_after(t0 + 4);
    tick();
    rst = 1'b1;
    check("mid_rst_valid", 64'(data_valid_o), 0);
    check("mid_rst_data", 64'(sa_data_o), 0);
    check("mid_rst_last", 64'(burst_last_o), 0);
    check("mid_rst_busy", 64'(busy_o), 0);
    check("mid_rst_wr_ready", 64'(wr_ready_o), 1);
    mdl_full = 2'b00; mdl_wp = 0; mdl_rp = 0;
    repeat (20) tick();
    fill(1'b0);
    drive_commit();
    wait_busy();
    weight_ready_i = 1'b1;
    t0 = cyc;
    push_burst(t0, mdl_rp, 8, 0, 0);
    tick();
    weight_ready_i = 1'b0;
    wait_done();
    release_model();

`ifdef FEEDER_STALL_EN
    // three stalled cycles starting at T+3
    fill(1'b0);
    burst_size_i = 11'd5;
    drive_commit();
    wait_busy();
    weight_ready_i = 1'b1;
    t0 = cyc;
    push_burst(t0, mdl_rp, 5, t0 + 3, 3);
    tick();
    weight_ready_i = 1'b0;
    while (cyc < t0 + 3) tick();
    sa_stall_i = 1'b1;
    repeat (3) tick();
    sa_stall_i = 1'b0;
    wait_done();
    release_model();
`endif

    repeat (5) tick();
    check("end_idle", 64'(busy_o), 0);
    check("end_wr_ready", 64'(wr_ready_o), 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_skew_feeder.md
Name: data_skew_feeder

Overview:
- Parametrised successor of the input-buffer/data-setup pair for the systolic array (SA) activation side.
- Holds NUM_LANES independent lane RAMs, double-buffered as ping/pong banks, so the host fills one bank while the other streams.
- Streams a committed bank into the SA with per-lane diagonal skew: lane k is delayed k cycles.
- Gated by the weight-side ready; flags the last element of each burst.

Parameters:
- NUM_LANES, 25, number of SA rows / lane RAMs
- DATA_WIDTH, 8, element width in bits
- DEPTH, 1024, entries per lane per bank
- BURST_W, 11, width of the burst-length input

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- wr_en  in  1  write strobe
- wr_lane  in  $clog2(NUM_LANES)  target lane
- wr_addr  in  $clog2(DEPTH)  entry within lane
- wr_data  in  DATA_WIDTH  write data
- wr_commit  in  1  marks current write bank full; write pointer toggles
- wr_ready_o  out  1  current write bank is empty and writable
- burst_size_i  in  BURST_W  elements per lane to stream
- weight_ready_i  in  1  weight side ready; starts streaming
- data_valid_o  out  NUM_LANES  per-lane valid
- sa_data_o  out  NUM_LANES*DATA_WIDTH  lane k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- burst_last_o  out  1  one-cycle pulse on the final element of lane NUM_LANES-1
- busy_o  out  1  FSM not IDLE

Behaviour:
- Reset (rst=0 at clk edge):
  - both banks empty; wr_ptr=rd_ptr=0; FSM IDLE
  - data_valid_o=0, sa_data_o=0, burst_last_o=0, busy_o=0, wr_ready_o=1
  - RAM contents undefined
  - reset mid-burst aborts the burst at once; no burst_last_o
- Write side:
  - wr_en && wr_ready_o writes bank wr_ptr, lane wr_lane, wr_addr.
  - Ignored when wr_ready_o=0 or wr_lane>=NUM_LANES.
  - wr_commit && wr_ready_o sets full[wr_ptr] and toggles wr_ptr. Ignored otherwise.
  - wr_en and wr_commit in the same cycle: the write lands first, then the commit.
- FSM states: IDLE, WAIT_W, STREAM, DRAIN.
  - IDLE: if full[rd_ptr] && burst_size_i!=0, latch len=min(burst_size_i, DEPTH) and go to WAIT_W. If burst_size_i==0, stay in IDLE.
  - WAIT_W: hold until weight_ready_i=1 (cycle T), then go to STREAM with rd_cnt=0.
  - STREAM: each cycle, issue read address rd_cnt to all lanes of bank rd_ptr and increment rd_cnt. The cycle rd_cnt==len-1 is issued, go to DRAIN. weight_ready_i is ignored after T.
  - DRAIN: count NUM_LANES cycles. On exit, clear full[rd_ptr], toggle rd_ptr, go to IDLE.
- Timing:
  - RAM read latency 1, then a registered skew chain of k stages for lane k.
  - Element i of lane k appears at cycle T+2+i+k with data_valid_o[k]=1.
  - sa_data_o lane k is 0 whenever data_valid_o[k]=0.
  - burst_last_o=1 exactly at cycle T+1+len+NUM_LANES-1.
  - Bank release takes effect on the following edge. Back-to-back bursts are therefore separated by at least one IDLE cycle.
- Concurrency:
  - Commit on one bank and release on the other in the same cycle: both take effect.
  - The write side never touches bank rd_ptr while it is full; this is guaranteed by wr_ready_o.
- Width rules:
  - rd_cnt and len are $clog2(DEPTH)+1 bits.
  - Clamp comparison is unsigned.

Optional Feature:
- Macro FEEDER_STALL_EN.
- Defined:
  - adds input sa_stall_i (1 bit)
  - while sa_stall_i=1: rd_cnt, the DRAIN counter, the RAM read enable and every skew register hold; outputs repeat their previous values; burst_last_o does not re-pulse
  - a stall in WAIT_W or IDLE has no effect
- Undefined:
  - port absent; no stall logic; timing exactly as in Behaviour.

Test Plan:
- Basic burst:
  - NUM_LANES=4, DEPTH=16.
  - Fill bank0 with lane k, addr a = 16k+a; commit; burst_size_i=5; weight_ready_i=1 at T.
  - Expect lane k values 16k..16k+4 at cycles T+2+k..T+6+k.
  - burst_last_o at T+9.
  - wr_ready_o=1 again after commit (bank1 writable).
- Ping-pong:
  - Commit bank0, then fill and commit bank1 during the bank0 burst; wr_ready_o=0 after the second commit.
  - Bank1 streams after bank0 release with no host gap beyond one IDLE cycle.
  - wr_ready_o returns to 1 on the edge after the first burst_last_o.
- Weight gating:
  - Bank full; weight_ready_i held 0 for 20 cycles.
  - FSM stays in WAIT_W, busy_o=1, data_valid_o=0.
  - Raise at T: first valid at T+2.
- Boundaries:
  - burst_size_i=0 with a full bank: stays IDLE, busy_o=0.
  - burst_size_i=2000 with DEPTH=16: streams exactly 16 elements per lane.
  - wr_lane=NUM_LANES: no RAM change.
- Reset mid-burst:
  - Assert rst=0 at T+4 of a len=8 burst.
  - Next cycle: all outputs 0, wr_ready_o=1, burst_last_o never pulses.
  - Re-commit and restream: correct data.
- FEEDER_STALL_EN:
  - sa_stall_i=1 for 3 cycles starting at T+3.
  - All lane sequences shift by 3 cycles with held values; burst_last_o moves from T+9 to T+12 and pulses once.
